// File: rtl/memory_access_stage_if.sv
// MEM-stage bus: EX/MEM control and data coming in, MEM/WB register and stall going out.
// The pipeline driver uses master; the MEM stage itself uses slave.
interface memory_access_stage_if;
    logic        EnableWriteBackIn;
    logic        EnableReadFromMemoryIn;
    logic        EnableWriteInMemoryIn;
    logic [31:0] PCIn;
    logic [31:0] ALUResultIn;
    logic [31:0] STValIn;
    logic [4:0]  destIn;

    logic        MemStall;
    logic        EnableWriteBackOutput;
    logic        MemToRegOutput;
    logic [31:0] PCOutput;
    logic [31:0] ALUResultOutput;
    logic [31:0] MemDataOutput;
    logic [4:0]  destOutput;

    modport master (
        output EnableWriteBackIn,
        output EnableReadFromMemoryIn,
        output EnableWriteInMemoryIn,
        output PCIn,
        output ALUResultIn,
        output STValIn,
        output destIn,
        input  MemStall,
        input  EnableWriteBackOutput,
        input  MemToRegOutput,
        input  PCOutput,
        input  ALUResultOutput,
        input  MemDataOutput,
        input  destOutput
    );

    modport slave (
        input  EnableWriteBackIn,
        input  EnableReadFromMemoryIn,
        input  EnableWriteInMemoryIn,
        input  PCIn,
        input  ALUResultIn,
        input  STValIn,
        input  destIn,
        output MemStall,
        output EnableWriteBackOutput,
        output MemToRegOutput,
        output PCOutput,
        output ALUResultOutput,
        output MemDataOutput,
        output destOutput
    );
endinterface

// File: rtl/memory_access_stage.sv
// MIPS MEM stage: word-addressed data memory with configurable access latency,
// stall generation towards upstream, and the MEM/WB pipeline register.
module memory_access_stage #(
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = 10,
    parameter int MEM_LATENCY = 0
) (
    input logic                  clk,
    input logic                  Reset,
    memory_access_stage_if.slave bus
);

    localparam bit LAT_EN = (MEM_LATENCY > 32'sd0);
    localparam int CNT_W  = (MEM_LATENCY > 32'sd1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_LOAD =
        CNT_W'(LAT_EN ? (MEM_LATENCY - 32'sd1) : 32'sd0);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [31:0]       mem_r [DEPTH];

    logic [ADDR_W-1:0] word_idx_s;
    logic              access_s;
    logic              stall_s;
    logic              wr_commit_s;
    logic [31:0]       rd_data_s;
    logic              unused_s;

    logic              wb_en_r;
    logic              mem_to_reg_r;
    logic [31:0]       pc_r;
    logic [31:0]       alu_result_r;
    logic [31:0]       mem_data_r;
    logic [4:0]        dest_r;

    // Byte address -> word index; the byte offset and the bits above the array wrap away.
    assign word_idx_s = bus.ALUResultIn[ADDR_W+1:2];
    assign access_s   = bus.EnableReadFromMemoryIn | bus.EnableWriteInMemoryIn;
    assign unused_s   = ^{bus.ALUResultIn[31:ADDR_W+2], bus.ALUResultIn[1:0]};

    // Stall while an access is still counting down; the completion cycle itself does not stall.
    always_comb begin
        stall_s = 1'b0;
        if (!LAT_EN || Reset) begin
            stall_s = 1'b0;
        end else if (state_r == IDLE) begin
            stall_s = access_s;
        end else begin
            stall_s = (cnt_r != CNT_ZERO);
        end
    end

    // A store commits only on the completion edge and never while reset is held.
    always_comb begin
        wr_commit_s = 1'b0;
        if (bus.EnableWriteInMemoryIn && !stall_s && !Reset) begin
            wr_commit_s = 1'b1;
        end else begin
            wr_commit_s = 1'b0;
        end
    end

    // Load data; when a store is also active the store value is forwarded (write-through).
    always_comb begin
        rd_data_s = 32'h0000_0000;
        if (bus.EnableWriteInMemoryIn) begin
            rd_data_s = bus.STValIn;
        end else if (bus.EnableReadFromMemoryIn) begin
            rd_data_s = mem_r[word_idx_s];
        end else begin
            rd_data_s = 32'h0000_0000;
        end
    end

    // Access-latency FSM: IDLE starts the countdown, BUSY returns to IDLE on the completion edge.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    if (LAT_EN && access_s) begin
                        state_r <= BUSY;
                        cnt_r   <= CNT_LOAD;
                    end else begin
                        state_r <= IDLE;
                        cnt_r   <= CNT_ZERO;
                    end
                end
                BUSY: begin
                    if (cnt_r != CNT_ZERO) begin
                        state_r <= BUSY;
                        cnt_r   <= cnt_r - CNT_ONE;
                    end else begin
                        state_r <= IDLE;
                        cnt_r   <= CNT_ZERO;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

    // Data array; deliberately outside the reset domain so its contents survive Reset.
    always_ff @(posedge clk) begin
        if (wr_commit_s) begin
            mem_r[word_idx_s] <= bus.STValIn;
        end
    end

    // MEM/WB register: a bubble on stall cycles (data held), full load on completion/pass-through.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            wb_en_r      <= 1'b0;
            mem_to_reg_r <= 1'b0;
            pc_r         <= 32'h0000_0000;
            alu_result_r <= 32'h0000_0000;
            mem_data_r   <= 32'h0000_0000;
            dest_r       <= 5'd0;
        end else if (stall_s) begin
            wb_en_r      <= 1'b0;
            mem_to_reg_r <= 1'b0;
        end else begin
            wb_en_r      <= bus.EnableWriteBackIn;
            mem_to_reg_r <= bus.EnableReadFromMemoryIn;
            pc_r         <= bus.PCIn;
            alu_result_r <= bus.ALUResultIn;
            mem_data_r   <= bus.EnableReadFromMemoryIn ? rd_data_s : 32'h0000_0000;
            dest_r       <= bus.destIn;
        end
    end

    assign bus.MemStall              = stall_s;
    assign bus.EnableWriteBackOutput = wb_en_r;
    assign bus.MemToRegOutput        = mem_to_reg_r;
    assign bus.PCOutput              = pc_r;
    assign bus.ALUResultOutput       = alu_result_r;
    assign bus.MemDataOutput         = mem_data_r;
    assign bus.destOutput            = dest_r;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage: one instance per access latency 0..3,
// stimulus steered to the instance selected by sel.
module tb_memory_access_stage;

    logic        clk = 1'b0;
    logic        Reset;
    logic [1:0]  sel;
    logic        d_wb, d_rd, d_wr;
    logic [31:0] d_pc, d_alu, d_st;
    logic [4:0]  d_dest;

    int passed = 0;
    int total  = 0;

    wire        stall_a [4];
    wire        wb_a    [4];
    wire        m2r_a   [4];
    wire [31:0] pc_a    [4];
    wire [31:0] alu_a   [4];
    wire [31:0] data_a  [4];
    wire [4:0]  dest_a  [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        memory_access_stage_if bus ();

        assign bus.EnableWriteBackIn      = (sel == 2'(g)) ? d_wb   : 1'b0;
        assign bus.EnableReadFromMemoryIn = (sel == 2'(g)) ? d_rd   : 1'b0;
        assign bus.EnableWriteInMemoryIn  = (sel == 2'(g)) ? d_wr   : 1'b0;
        assign bus.PCIn                   = (sel == 2'(g)) ? d_pc   : 32'h0;
        assign bus.ALUResultIn            = (sel == 2'(g)) ? d_alu  : 32'h0;
        assign bus.STValIn                = (sel == 2'(g)) ? d_st   : 32'h0;
        assign bus.destIn                 = (sel == 2'(g)) ? d_dest : 5'd0;

        memory_access_stage #(
            .DEPTH       (1024),
            .ADDR_W      (10),
            .MEM_LATENCY (g)
        ) u_dut (
            .clk   (clk),
            .Reset (Reset),
            .bus   (bus)
        );

        assign stall_a[g] = bus.MemStall;
        assign wb_a[g]    = bus.EnableWriteBackOutput;
        assign m2r_a[g]   = bus.MemToRegOutput;
        assign pc_a[g]    = bus.PCOutput;
        assign alu_a[g]   = bus.ALUResultOutput;
        assign data_a[g]  = bus.MemDataOutput;
        assign dest_a[g]  = bus.destOutput;
    end

    task automatic set_idle();
        d_wb = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
        d_pc = 32'h0; d_alu = 32'h0; d_st = 32'h0; d_dest = 5'd0;
    endtask

    // Waits for the falling edge, then presents one EX/MEM instruction.
    task automatic apply(input logic wb, input logic rd, input logic wr, input logic [31:0] pc,
                         input logic [31:0] alu, input logic [31:0] st, input logic [4:0] dest);
        @(negedge clk);
        d_wb = wb; d_rd = rd; d_wr = wr; d_pc = pc; d_alu = alu; d_st = st; d_dest = dest;
    endtask

    // Holds the presented access until completion; returns stall count and bubble violations.
    task automatic run_access(output int stalls, output int bad_bubbles, output bit done);
        stalls = 0; bad_bubbles = 0; done = 1'b0;
        for (int c = 0; c < 16 && !done; c++) begin
            #1;
            if (stall_a[sel] === 1'b1) stalls++;
            else done = 1'b1;
            @(posedge clk); #1;
            if (!done && wb_a[sel] !== 1'b0) bad_bubbles++;
            if (!done) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            total++; if (stall_a[k] !== 1'b0) $display("FAIL reset_stall[%0d]: got %b expected 0", k, stall_a[k]); else passed++;
            total++; if (wb_a[k] !== 1'b0) $display("FAIL reset_wb[%0d]: got %b expected 0", k, wb_a[k]); else passed++;
            total++; if (data_a[k] !== 32'h0) $display("FAIL reset_data[%0d]: got %h expected 0", k, data_a[k]); else passed++;
            total++; if (pc_a[k] !== 32'h0) $display("FAIL reset_pc[%0d]: got %h expected 0", k, pc_a[k]); else passed++;
        end
        @(negedge clk);
        Reset = 1'b0;
    endtask

    task automatic test_lat0_store_load();
        sel = 2'd0;
        apply(1'b0, 1'b0, 1'b1, 32'h100, 32'h10, 32'hDEADBEEF, 5'd0);
        #1;
        total++; if (stall_a[0] !== 1'b0) $display("FAIL lat0_sw_stall: got %b expected 0", stall_a[0]); else passed++;
        @(posedge clk); #1;
        total++; if (m2r_a[0] !== 1'b0) $display("FAIL lat0_sw_m2r: got %b expected 0", m2r_a[0]); else passed++;
        total++; if (data_a[0] !== 32'h0) $display("FAIL lat0_sw_data: got %h expected 0", data_a[0]); else passed++;
        apply(1'b1, 1'b1, 1'b0, 32'h104, 32'h10, 32'h0, 5'd3);
        #1;
        total++; if (stall_a[0] !== 1'b0) $display("FAIL lat0_lw_stall: got %b expected 0", stall_a[0]); else passed++;
        @(posedge clk); #1;
        total++; if (data_a[0] !== 32'hDEADBEEF) $display("FAIL lat0_lw_data: got %h expected deadbeef", data_a[0]); else passed++;
        total++; if (m2r_a[0] !== 1'b1) $display("FAIL lat0_lw_m2r: got %b expected 1", m2r_a[0]); else passed++;
        total++; if (wb_a[0] !== 1'b1) $display("FAIL lat0_lw_wb: got %b expected 1", wb_a[0]); else passed++;
        total++; if (dest_a[0] !== 5'd3) $display("FAIL lat0_lw_dest: got %0d expected 3", dest_a[0]); else passed++;
        total++; if (pc_a[0] !== 32'h104) $display("FAIL lat0_lw_pc: got %h expected 104", pc_a[0]); else passed++;
    endtask

    task automatic test_wrap();
        sel = 2'd0;
        apply(1'b0, 1'b0, 1'b1, 32'h110, 32'h1004, 32'h12345678, 5'd0);
        @(posedge clk);
        apply(1'b1, 1'b1, 1'b0, 32'h114, 32'h0004, 32'h0, 5'd2);
        @(posedge clk); #1;
        total++; if (data_a[0] !== 32'h12345678) $display("FAIL wrap_lw4: got %h expected 12345678", data_a[0]); else passed++;
        apply(1'b1, 1'b1, 1'b0, 32'h118, 32'h0007, 32'h0, 5'd2);
        @(posedge clk); #1;
        total++; if (data_a[0] !== 32'h12345678) $display("FAIL wrap_lw7: got %h expected 12345678", data_a[0]); else passed++;
        total++; if (alu_a[0] !== 32'h7) $display("FAIL wrap_alu: got %h expected 7", alu_a[0]); else passed++;
    endtask

    task automatic test_read_write();
        sel = 2'd0;
        apply(1'b1, 1'b1, 1'b1, 32'h200, 32'h8, 32'hA5A5A5A5, 5'd9);
        #1;
        total++; if (stall_a[0] !== 1'b0) $display("FAIL rw_stall: got %b expected 0", stall_a[0]); else passed++;
        @(posedge clk); #1;
        total++; if (data_a[0] !== 32'hA5A5A5A5) $display("FAIL rw_data: got %h expected a5a5a5a5", data_a[0]); else passed++;
        total++; if (m2r_a[0] !== 1'b1) $display("FAIL rw_m2r: got %b expected 1", m2r_a[0]); else passed++;
        apply(1'b1, 1'b1, 1'b0, 32'h204, 32'h8, 32'h0, 5'd9);
        @(posedge clk); #1;
        total++; if (data_a[0] !== 32'hA5A5A5A5) $display("FAIL rw_lw_data: got %h expected a5a5a5a5", data_a[0]); else passed++;
        apply(1'b1, 1'b0, 1'b1, 32'h208, 32'hC, 32'h11111111, 5'd9);
        @(posedge clk); #1;
        total++; if (data_a[0] !== 32'h0) $display("FAIL sw_only_data: got %h expected 0", data_a[0]); else passed++;
    endtask

    task automatic test_alu_only();
        sel = 2'd1;
        apply(1'b1, 1'b0, 1'b0, 32'h40, 32'h55, 32'h0, 5'd7);
        #1;
        total++; if (stall_a[1] !== 1'b0) $display("FAIL alu_stall: got %b expected 0", stall_a[1]); else passed++;
        @(posedge clk); #1;
        total++; if (wb_a[1] !== 1'b1) $display("FAIL alu_wb: got %b expected 1", wb_a[1]); else passed++;
        total++; if (dest_a[1] !== 5'd7) $display("FAIL alu_dest: got %0d expected 7", dest_a[1]); else passed++;
        total++; if (alu_a[1] !== 32'h55) $display("FAIL alu_result: got %h expected 55", alu_a[1]); else passed++;
        total++; if (m2r_a[1] !== 1'b0) $display("FAIL alu_m2r: got %b expected 0", m2r_a[1]); else passed++;
        total++; if (pc_a[1] !== 32'h40) $display("FAIL alu_pc: got %h expected 40", pc_a[1]); else passed++;
    endtask

    task automatic test_back_to_back();
        int  st, bad;
        bit  done;
        sel = 2'd3;
        apply(1'b0, 1'b0, 1'b1, 32'h300, 32'h10, 32'hCAFEF00D, 5'd0);
        run_access(st, bad, done);
        total++; if (done !== 1'b1) $display("FAIL lat3_sw_timeout: got done=%b expected 1", done); else passed++;
        total++; if (st !== 3) $display("FAIL lat3_sw_stalls: got %0d expected 3", st); else passed++;
        // load presented on the very next cycle, no idle gap
        apply(1'b1, 1'b1, 1'b0, 32'h304, 32'h10, 32'h0, 5'd6);
        run_access(st, bad, done);
        total++; if (done !== 1'b1) $display("FAIL lat3_lw_timeout: got done=%b expected 1", done); else passed++;
        total++; if (st !== 3) $display("FAIL lat3_lw_stalls: got %0d expected 3", st); else passed++;
        total++; if (bad !== 0) $display("FAIL lat3_lw_bubbles: got %0d non-bubble stall cycles expected 0", bad); else passed++;
        total++; if (data_a[3] !== 32'hCAFEF00D) $display("FAIL lat3_lw_data: got %h expected cafef00d", data_a[3]); else passed++;
        total++; if (wb_a[3] !== 1'b1) $display("FAIL lat3_lw_wb: got %b expected 1", wb_a[3]); else passed++;
        total++; if (m2r_a[3] !== 1'b1) $display("FAIL lat3_lw_m2r: got %b expected 1", m2r_a[3]); else passed++;
        total++; if (dest_a[3] !== 5'd6) $display("FAIL lat3_lw_dest: got %0d expected 6", dest_a[3]); else passed++;
    endtask

    task automatic test_reset_during_busy();
        int  st, bad;
        bit  done;
        sel = 2'd2;
        // known starting content at 0x20
        apply(1'b0, 1'b0, 1'b1, 32'h400, 32'h20, 32'h0, 5'd0);
        run_access(st, bad, done);
        total++; if (st !== 2) $display("FAIL lat2_init_stalls: got %0d expected 2", st); else passed++;
        apply(1'b0, 1'b0, 1'b1, 32'h404, 32'h20, 32'h5, 5'd0);
        #1;
        total++; if (stall_a[2] !== 1'b1) $display("FAIL lat2_stall1: got %b expected 1", stall_a[2]); else passed++;
        @(posedge clk);
        @(negedge clk); #1;
        total++; if (stall_a[2] !== 1'b1) $display("FAIL lat2_stall2: got %b expected 1", stall_a[2]); else passed++;
        Reset = 1'b1;
        #1;
        total++; if (stall_a[2] !== 1'b0) $display("FAIL rst_busy_stall: got %b expected 0", stall_a[2]); else passed++;
        total++; if (pc_a[2] !== 32'h0) $display("FAIL rst_busy_pc: got %h expected 0", pc_a[2]); else passed++;
        total++; if (alu_a[2] !== 32'h0) $display("FAIL rst_busy_alu: got %h expected 0", alu_a[2]); else passed++;
        total++; if (wb_a[2] !== 1'b0 || m2r_a[2] !== 1'b0 || dest_a[2] !== 5'd0 || data_a[2] !== 32'h0)
            $display("FAIL rst_busy_outputs: got wb=%b m2r=%b dest=%0d data=%h expected all 0", wb_a[2], m2r_a[2], dest_a[2], data_a[2]);
        else passed++;
        set_idle();
        @(negedge clk);
        Reset = 1'b0;
        apply(1'b1, 1'b1, 1'b0, 32'h408, 32'h20, 32'h0, 5'd4);
        run_access(st, bad, done);
        total++; if (st !== 2) $display("FAIL lat2_lw_stalls: got %0d expected 2", st); else passed++;
        total++; if (data_a[2] !== 32'h0) $display("FAIL rst_busy_mem_kept: got %h expected 0", data_a[2]); else passed++;
        total++; if (m2r_a[2] !== 1'b1) $display("FAIL lat2_lw_m2r: got %b expected 1", m2r_a[2]); else passed++;
    endtask

    initial begin
        Reset = 1'b1;
        sel   = 2'd0;
        set_idle();
        test_reset();
        test_lat0_store_load();
        test_wrap();
        test_read_write();
        test_alu_only();
        test_back_to_back();
        test_reset_during_busy();
        @(negedge clk);
        set_idle();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
